// File: rtl/instr_fetch.sv
// instr_fetch: instruction-issue sequencer feeding the control unit.
// Holds a 2^PC_BITS-word program memory. Each instruction is kept on `instr`
// for as many cycles as the control unit needs for its type. The first
// instruction gets one extra wake cycle.
module instr_fetch #(
  parameter int INSTR_WIDTH = 20,
  parameter int PC_BITS     = 5
) (
  input  logic                   clk,
  input  logic                   rst,        // asynchronous, active low
  input  logic                   start,
  input  logic                   prog_we,
  input  logic [PC_BITS-1:0]     prog_addr,
  input  logic [INSTR_WIDTH-1:0] prog_data,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [PC_BITS-1:0]     pc,
  output logic                   busy,
  output logic                   done,
  output logic [PC_BITS:0]       n_issued
);

  localparam int DEPTH = 1 << PC_BITS;
  localparam logic [PC_BITS-1:0] PC_LAST = PC_BITS'(DEPTH - 1);
  localparam logic [PC_BITS:0]   N_MAX   = '1;
  localparam logic [PC_BITS:0]   N_ONE   = (PC_BITS+1)'(1);

  typedef enum logic [1:0] {IDLE, WAKE, ISSUE, HALT} state_t;

  state_t                 state_reg, state_next;
  logic [INSTR_WIDTH-1:0] instr_reg, instr_next;
  logic [PC_BITS-1:0]     pc_reg, pc_next;
  logic [1:0]             cnt_reg, cnt_next;
  logic [PC_BITS:0]       n_reg, n_next;
  logic                   busy_reg, done_reg;

  logic [INSTR_WIDTH-1:0] mem [DEPTH];
  logic [PC_BITS-1:0]     pc_succ;
  logic [INSTR_WIDTH-1:0] word_first, word_succ;

  // Remaining hold cycles after the first, indexed by the type field.
  // loadR (2'b10) needs 4 cycles; std_op and storeR need 3.
  function automatic logic [1:0] hold_m1(input logic [INSTR_WIDTH-1:0] w);
    return (w[INSTR_WIDTH-1 -: 2] == 2'b10) ? 2'd3 : 2'd2;
  endfunction

  // Type 2'b00 marks the end of the program.
  function automatic logic is_end(input logic [INSTR_WIDTH-1:0] w);
    return (w[INSTR_WIDTH-1 -: 2] == 2'b00);
  endfunction

  assign pc_succ    = pc_reg + PC_BITS'(1);
  assign word_first = mem[0];
  assign word_succ  = mem[pc_succ];

  // Program memory: writable only while the issue engine is not running.
  // Reset does not clear it.
  always_ff @(posedge clk) begin
    if (prog_we && (state_reg == IDLE || state_reg == HALT))
      mem[prog_addr] <= prog_data;
  end

  // Next-state and next-output logic for the issue sequencer.
  always_comb begin
    state_next = state_reg;
    instr_next = instr_reg;
    pc_next    = pc_reg;
    cnt_next   = cnt_reg;
    n_next     = n_reg;
    case (state_reg)
      IDLE: begin
        // A write in the same cycle takes priority over start.
        if (start && !prog_we) begin
          if (is_end(word_first)) begin
            instr_next = '0;
            state_next = HALT;
          end else begin
            instr_next = word_first;
            pc_next    = '0;
            n_next     = N_ONE;
            state_next = WAKE;
          end
        end
      end
      WAKE: begin
        // One cycle so the control unit can leave its own reset state.
        cnt_next   = hold_m1(instr_reg);
        state_next = ISSUE;
      end
      ISSUE: begin
        if (cnt_reg != 2'd0) begin
          cnt_next = cnt_reg - 2'd1;
        end else if (pc_reg == PC_LAST) begin
          // Ran off the end of memory: stop without wrapping pc.
          instr_next = '0;
          state_next = HALT;
        end else begin
          pc_next = pc_succ;
          if (is_end(word_succ)) begin
            instr_next = '0;
            state_next = HALT;
          end else begin
            instr_next = word_succ;
            cnt_next   = hold_m1(word_succ);
            n_next     = (n_reg == N_MAX) ? n_reg : n_reg + N_ONE;
          end
        end
      end
      HALT: begin
        instr_next = '0;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and output registers. busy and done come from the next state, so
  // they line up with the state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      instr_reg <= '0;
      pc_reg    <= '0;
      cnt_reg   <= '0;
      n_reg     <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      instr_reg <= instr_next;
      pc_reg    <= pc_next;
      cnt_reg   <= cnt_next;
      n_reg     <= n_next;
      busy_reg  <= (state_next == WAKE) || (state_next == ISSUE);
      done_reg  <= (state_next == HALT);
    end
  end

  assign instr    = instr_reg;
  assign pc       = pc_reg;
  assign busy     = busy_reg;
  assign done     = done_reg;
  assign n_issued = n_reg;

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Instruction-issue sequencer that drives the 20-bit `instr` bus consumed by the control unit.
- Holds a small program memory and presents one instruction at a time.
- Keeps each instruction stable for exactly the number of cycles the control unit needs for that instruction type: std_op 3, loadR 4, storeR 3, plus 1 wake cycle for the first instruction.
- Sits between the testbench/loader and the control unit. It is the producer end of the instruction interface.

Parameters:
- INSTR_WIDTH, 20, instruction word width. Type field is [19:18].
- PC_BITS, 5, program counter width; program memory depth is 2^PC_BITS (32 words).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  begin issuing from address 0. Sampled in IDLE only.
- prog_we  in  1  program memory write enable. Honoured only in IDLE or HALT.
- prog_addr  in  PC_BITS  program memory write address.
- prog_data  in  INSTR_WIDTH  program memory write data.
- instr  out  INSTR_WIDTH  registered instruction driven to the control unit.
- pc  out  PC_BITS  address of the word currently on instr.
- busy  out  1  high in WAKE and ISSUE.
- done  out  1  high in HALT.
- n_issued  out  PC_BITS+1  count of instructions issued since reset, saturating.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; instr=0, pc=0, busy=0, done=0, n_issued=0, hold counter=0. Program memory is NOT cleared by reset.
- Hold length by type: 2'b01 gives 3, 2'b10 gives 4, 2'b11 gives 3. Type 2'b00 is the end-of-program marker and is never issued.
- States: IDLE, WAKE, ISSUE, HALT.
- IDLE:
  - prog_we=1 writes mem[prog_addr]=prog_data on the edge. prog_we has priority over start.
  - start=1 with prog_we=0: read mem[0].
  - If mem[0] type=00: go to HALT, instr stays 0.
  - Otherwise: instr<=mem[0], pc<=0, n_issued<=1, go to WAKE.
- WAKE: lasts exactly 1 cycle, so the control unit can leave its RESET state. Load cnt<=hold(instr)-1 and go to ISSUE. instr is unchanged.
- ISSUE: on each edge where cnt!=0, cnt<=cnt-1. On the edge where cnt==0 (end of hold):
  - If pc==2^PC_BITS-1 (wrap): instr<=0, go to HALT. pc is not incremented.
  - Else if mem[pc+1] type=00: pc<=pc+1, instr<=0, go to HALT.
  - Else: pc<=pc+1, instr<=mem[pc+1], cnt<=hold(mem[pc+1])-1, n_issued<=n_issued+1. Stay in ISSUE.
- Resulting instr stability: first instruction held hold+1 cycles; every later instruction held exactly hold cycles. The new word appears on the same edge at which the control unit samples the last cycle of the old one.
- HALT: instr=0, done=1, busy=0. start is ignored. prog_we writes are allowed. Exit only via rst.
- In WAKE/ISSUE, prog_we and start are ignored and memory is unchanged.
- Reset mid-operation: outputs go to their reset values immediately, without waiting for a clock edge. Program memory is retained, so a fresh start replays the program from address 0.
- n_issued saturates at 2^(PC_BITS+1)-1. It cannot exceed 2^PC_BITS in practice.
- Memory read is combinational inside the block. All outputs are registered.

Test Plan:
- mem[0]=20'h5B002 (std_op), mem[1]=0; start pulse at edge 0 -> instr=20'h5B002 for 4 cycles (edges 1–4), then instr=0, done=1, pc=1, n_issued=1, busy=0.
- mem[0]=20'h84050 (loadR), mem[1]=20'h5B002, mem[2]=20'hC4060 (storeR), mem[3]=0; start -> hold durations are 5, 3, 3 cycles, then HALT with pc=3, n_issued=3.
- All 32 words = 20'h5B002; start -> 32 instructions issued, HALT after word 31 with pc=31, n_issued=32, instr=0.
- mem[0]=0; start -> HALT one edge later, instr never leaves 0, n_issued=0.
- Program mem[0..1] as in the second scenario (loadR, std_op); start; during ISSUE assert prog_we with prog_addr=1, prog_data=20'h7F00F -> write ignored; mem[1]=20'h5B002 is still issued.
- Same program as the second scenario; drive rst=0 mid-hold of mem[1] -> instr=0, busy=0 before the next edge. Release rst, pulse start -> identical 5/3/3 issue sequence reproduced.
